// File: rtl/sample_wr_ctrl.sv
// sample_wr_ctrl: write-side controller for the interpolation filter's circular sample RAM
module sample_wr_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int PRIME_DEPTH = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              rd_advance,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W:0]   fill_level,
  output logic              underflow_err
);
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PRIME_L = (ADDR_W+1)'(PRIME_DEPTH);
  typedef enum logic [1:0] {FILL, RUN, STARVE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic accept, consume, underflow;
  always_ff @(posedge clk)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == RUN) ? (underflow ? STARVE : RUN)
             : (fill_level >= PRIME_L) ? RUN : state;
  end
  // rd_en decodes the state register, so it rises on the edge that enters RUN
  always_comb begin
    rd_en     = (state == RUN);
    s_ready   = (fill_level < DEPTH_L);
    accept    = s_valid & s_ready;
    consume   = rd_advance & rd_en & (fill_level != '0);
    underflow = rd_advance & rd_en & (fill_level == '0);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_ptr        <= '0;
      fill_level    <= '0;
      underflow_err <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= wr_ptr;
        wr_data <= s_data;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      fill_level    <= (accept && !consume) ? fill_level + 1'b1
                     : (consume && !accept) ? fill_level - 1'b1 : fill_level;
      underflow_err <= underflow | (underflow_err & ~err_clr);
    end
endmodule

// File: tb/tb_sample_wr_ctrl.sv
// tb_sample_wr_ctrl: directed scenarios for the sample RAM write controller
module tb_sample_wr_ctrl;
  logic clk = 1'b0;
  logic rst_n, s_valid, s_ready, rd_advance, err_clr, wr_en, rd_en, underflow_err;
  logic [15:0] s_data, wr_data;
  logic [7:0] wr_addr;
  logic [8:0] fill_level;
  logic [15:0] ram [256];
  int checks = 0;
  int errors = 0;
  sample_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rd_advance(rd_advance), .err_clr(err_clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .fill_level(fill_level), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (wr_en) ram[wr_addr] <= wr_data;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; rd_advance = 1'b0; err_clr = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask
  task automatic prime();
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      cyc();
    end
    s_valid = 1'b0;
    cyc();
  endtask
  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({wr_en, wr_addr, wr_data, rd_en, fill_level, underflow_err, s_ready} !== {1'b0, 8'd0, 16'd0, 1'b0, 9'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: wr_en=%0b wr_addr=%0d wr_data=%0h rd_en=%0b fill=%0d uf=%0b s_ready=%0b, expected all 0 with s_ready=1",
               wr_en, wr_addr, wr_data, rd_en, fill_level, underflow_err, s_ready);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_prime();
    for (int i = 1; i <= 25; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      cyc();
      checks++;
      if ({wr_en, wr_addr, wr_data, fill_level, rd_en} !== {1'b1, 8'(i-1), 16'(i), 9'(i), 1'b0}) begin
        errors++;
        $display("FAIL prime_write[%0d]: wr_en=%0b addr=%0d data=%0h fill=%0d rd_en=%0b, expected 1 %0d %0h %0d 0",
                 i, wr_en, wr_addr, wr_data, fill_level, rd_en, i-1, i, i);
      end
    end
    s_valid = 1'b0;
    cyc();
    checks++;
    if ({rd_en, wr_en, fill_level} !== {1'b1, 1'b0, 9'd25}) begin
      errors++;
      $display("FAIL prime_done: rd_en=%0b wr_en=%0b fill=%0d, expected 1 0 25", rd_en, wr_en, fill_level);
    end
  endtask
  task automatic test_underflow();
    for (int i = 1; i <= 25; i++) begin
      rd_advance = 1'b1;
      cyc();
      checks++;
      if (fill_level !== 9'(25-i)) begin
        errors++;
        $display("FAIL drain[%0d]: fill=%0d, expected %0d", i, fill_level, 25-i);
      end
    end
    err_clr = 1'b1;
    cyc();
    checks++;
    if ({underflow_err, rd_en, fill_level} !== {1'b1, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL underflow: uf=%0b rd_en=%0b fill=%0d, expected 1 0 0", underflow_err, rd_en, fill_level);
    end
    rd_advance = 1'b0;
    cyc();
    checks++;
    if (underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: uf=%0b, expected 0", underflow_err);
    end
    err_clr = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      s_valid = 1'b1; s_data = 16'(i); rd_advance = 1'b1;
      cyc();
    end
    s_valid = 1'b0; rd_advance = 1'b0;
    checks++;
    if ({fill_level, rd_en, underflow_err} !== {9'd25, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reprime: fill=%0d rd_en=%0b uf=%0b, expected 25 0 0", fill_level, rd_en, underflow_err);
    end
    cyc();
    checks++;
    if (rd_en !== 1'b1) begin
      errors++;
      $display("FAIL reprime_run: rd_en=%0b, expected 1", rd_en);
    end
  endtask
  task automatic test_full();
    prime();
    for (int i = 0; i < 231; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      cyc();
    end
    checks++;
    if ({fill_level, s_ready} !== {9'd256, 1'b0}) begin
      errors++;
      $display("FAIL full: fill=%0d s_ready=%0b, expected 256 0", fill_level, s_ready);
    end
    rd_advance = 1'b1;
    cyc();
    checks++;
    if ({fill_level, s_ready, wr_en} !== {9'd255, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_consume: fill=%0d s_ready=%0b wr_en=%0b, expected 255 1 0", fill_level, s_ready, wr_en);
    end
    rd_advance = 1'b0;
    cyc();
    checks++;
    if ({fill_level, s_ready, wr_en} !== {9'd256, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_refill: fill=%0d s_ready=%0b wr_en=%0b, expected 256 0 1", fill_level, s_ready, wr_en);
    end
    s_valid = 1'b0;
  endtask
  task automatic test_wrap();
    int n = 0;
    int cnt = 0;
    logic acc;
    do_reset();
    while (n < 300 && cnt < 5000) begin
      s_valid = 1'b1; s_data = 16'(n+1); rd_advance = (cnt % 25 == 24);
      acc = s_ready;
      cyc();
      if (acc) n++;
      cnt++;
    end
    s_valid = 1'b0; rd_advance = 1'b0;
    checks++;
    if (n != 300) begin
      errors++;
      $display("FAIL wrap_timeout: accepted %0d, expected 300", n);
    end
    cyc();
    checks++;
    if ({ram[0], ram[1], ram[255], wr_addr} !== {16'd257, 16'd258, 16'd256, 8'd43}) begin
      errors++;
      $display("FAIL wrap: ram0=%0d ram1=%0d ram255=%0d wr_addr=%0d, expected 257 258 256 43", ram[0], ram[1], ram[255], wr_addr);
    end
  endtask
  task automatic test_coincident();
    prime();
    for (int i = 0; i < 15; i++) begin
      rd_advance = 1'b1;
      cyc();
    end
    checks++;
    if (fill_level !== 9'd10) begin
      errors++;
      $display("FAIL coinc_pre: fill=%0d, expected 10", fill_level);
    end
    s_valid = 1'b1; s_data = 16'hbeef;
    cyc();
    checks++;
    if ({fill_level, wr_en, wr_data, rd_en} !== {9'd10, 1'b1, 16'hbeef, 1'b1}) begin
      errors++;
      $display("FAIL coinc: fill=%0d wr_en=%0b data=%0h rd_en=%0b, expected 10 1 beef 1", fill_level, wr_en, wr_data, rd_en);
    end
    s_valid = 1'b0; rd_advance = 1'b0;
  endtask
  task automatic test_mid_reset();
    prime();
    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1; s_data = 16'(100+i);
      cyc();
    end
    s_valid = 1'b0;
    checks++;
    if ({fill_level, rd_en} !== {9'd40, 1'b1}) begin
      errors++;
      $display("FAIL midrst_pre: fill=%0d rd_en=%0b, expected 40 1", fill_level, rd_en);
    end
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({wr_en, wr_addr, wr_data, rd_en, fill_level, underflow_err} !== 28'd0) begin
      errors++;
      $display("FAIL midrst: wr_en=%0b addr=%0d data=%0h rd_en=%0b fill=%0d uf=%0b, expected all 0",
               wr_en, wr_addr, wr_data, rd_en, fill_level, underflow_err);
    end
    rst_n = 1'b1; rd_advance = 1'b1;
    cyc();
    checks++;
    if ({fill_level, rd_en, underflow_err} !== {9'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_ignore: fill=%0d rd_en=%0b uf=%0b, expected 0 0 0", fill_level, rd_en, underflow_err);
    end
    rd_advance = 1'b0;
  endtask
  initial begin
    test_reset();
    test_prime();
    test_underflow();
    test_full();
    test_wrap();
    test_coincident();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
